store_merge_unit: RTL and testbench

- Store-side counterpart of the load sign-extension path. Takes a byte, halfword or word store from the datapath and writes it into a word-wide data memory that has no byte enables.
- Word stores are written directly.
- Sub-word stores use a read-modify-write sequence: read the containing word, merge the new lanes, write the word back.
- Sits between the execute stage and the data memory port. Flags misaligned accesses and memory timeouts.

---
 rtl/store_merge_unit.sv | 203 ++++++++++++++++++++
 tb/tb_store_merge_unit.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/store_merge_unit.sv
// Store path into a word-wide data memory without byte enables.
// Word stores write directly; byte/halfword stores read-modify-write the containing word.
module store_merge_unit #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned MAX_WAIT   = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  StoreReq,
  input  logic [ADDR_WIDTH-1:0] Addr,
  input  logic [31:0]           StoreData,
  input  logic [1:0]            StoreSelector,
  output logic [ADDR_WIDTH-1:0] MemAddr,
  output logic                  MemRead,
  output logic                  MemWrite,
  output logic [31:0]           MemWdata,
  input  logic [31:0]           MemRdata,
  input  logic                  MemReady,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Misaligned,
  output logic                  Timeout
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned HALF_W = 16;
  localparam int unsigned CNT_W  = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);

  localparam logic [1:0] SEL_BYTE = 2'b00;
  localparam logic [1:0] SEL_HALF = 2'b01;
  localparam logic [1:0] SEL_WORD = 2'b10;

  // Last count value before the wait budget is exhausted.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_MERGE,
    S_WRITE,
    S_DONE
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   maddr_q, maddr_d;
  logic [1:0]              lane_q, lane_d;
  logic [HALF_W-1:0]       data_q, data_d;
  logic                    half_q, half_d;
  logic [DATA_W-1:0]       buf_q, buf_d;
  logic [DATA_W-1:0]       wdata_q, wdata_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    rd_q, rd_d;
  logic                    wr_q, wr_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    mis_q, mis_d;
  logic                    tmo_q, tmo_d;

  logic                    misalign;
  logic [DATA_W-1:0]       merged;

  // Alignment check on the live request inputs.
  always_comb begin
    misalign = 1'b0;
    unique case (StoreSelector)
      SEL_BYTE: misalign = 1'b0;
      SEL_HALF: misalign = Addr[0];
      SEL_WORD: misalign = |Addr[1:0];
      default:  misalign = 1'b1;
    endcase
  end

  // Replace the addressed lane(s) of the read-back word.
  always_comb begin
    merged = buf_q;
    if (half_q) begin
      merged[{lane_q[1], 4'b0000} +: HALF_W] = data_q;
    end else begin
      merged[{lane_q, 3'b000} +: 8] = data_q[7:0];
    end
  end

  always_comb begin
    state_d = state_q;
    maddr_d = maddr_q;
    lane_d  = lane_q;
    data_d  = data_q;
    half_d  = half_q;
    buf_d   = buf_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    mis_d   = 1'b0;
    tmo_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (StoreReq) begin
          maddr_d = {Addr[ADDR_WIDTH-1:2], 2'b00};
          lane_d  = Addr[1:0];
          data_d  = StoreData[HALF_W-1:0];
          half_d  = (StoreSelector == SEL_HALF);
          cnt_d   = '0;
          if (misalign) begin
            mis_d   = 1'b1;
            state_d = S_DONE;
          end else if (StoreSelector == SEL_WORD) begin
            wdata_d = StoreData;
            state_d = S_WRITE;
          end else begin
            state_d = S_READ;
          end
        end
      end

      S_READ: begin
        if (MemReady) begin
          buf_d   = MemRdata;
          state_d = S_MERGE;
        end else if (cnt_q == CNT_LAST) begin
          tmo_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_MERGE: begin
        wdata_d = merged;
        cnt_d   = '0;
        state_d = S_WRITE;
      end

      S_WRITE: begin
        if (MemReady) begin
          state_d = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          tmo_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Strobes and status follow the state being entered, so they are registered.
    rd_d   = (state_d == S_READ);
    wr_d   = (state_d == S_WRITE);
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      maddr_q <= '0;
      lane_q  <= '0;
      data_q  <= '0;
      half_q  <= 1'b0;
      buf_q   <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      mis_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      maddr_q <= maddr_d;
      lane_q  <= lane_d;
      data_q  <= data_d;
      half_q  <= half_d;
      buf_q   <= buf_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      mis_q   <= mis_d;
      tmo_q   <= tmo_d;
    end
  end

  assign MemAddr    = maddr_q;
  assign MemRead    = rd_q;
  assign MemWrite   = wr_q;
  assign MemWdata   = wdata_q;
  assign Busy       = busy_q;
  assign Done       = done_q;
  assign Misaligned = mis_q;
  assign Timeout    = tmo_q;

endmodule

// File: tb/tb_store_merge_unit.sv
// Directed bench for store_merge_unit: cycle-accurate strobe/done timing, merge data,
// misalignment, timeout, mid-operation reset and request-while-busy.
module tb_store_merge_unit;

  localparam int unsigned AW = 32;
  localparam int unsigned MW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          StoreReq;
  logic [AW-1:0] Addr;
  logic [31:0]   StoreData;
  logic [1:0]    StoreSelector;
  logic [AW-1:0] MemAddr;
  logic          MemRead;
  logic          MemWrite;
  logic [31:0]   MemWdata;
  logic [31:0]   MemRdata;
  logic          MemReady;
  logic          Busy;
  logic          Done;
  logic          Misaligned;
  logic          Timeout;

  int checks = 0;
  int errors = 0;

  int          r_rd_first, r_rd_cnt, r_wr_first, r_wr_cnt, r_done;
  logic [31:0] r_raddr, r_waddr, r_wdata;
  logic        r_mis, r_tmo, r_both, r_busy1;

  store_merge_unit #(.ADDR_WIDTH(AW), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst_n(rst_n), .StoreReq(StoreReq), .Addr(Addr),
    .StoreData(StoreData), .StoreSelector(StoreSelector), .MemAddr(MemAddr),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemWdata(MemWdata),
    .MemRdata(MemRdata), .MemReady(MemReady), .Busy(Busy), .Done(Done),
    .Misaligned(Misaligned), .Timeout(Timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one store (cycle 0) and trace the strobes until Done; memory answers after rdly strobe cycles.
  task automatic run_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                           input int rdly, input bit hold);
    int scnt;
    bit prev;
    r_rd_first = -1; r_rd_cnt = 0; r_wr_first = -1; r_wr_cnt = 0; r_done = -1;
    r_raddr = '0; r_waddr = '0; r_wdata = '0;
    r_mis = 1'b0; r_tmo = 1'b0; r_both = 1'b0; r_busy1 = 1'b0;
    scnt = 0;
    prev = 1'b0;
    @(negedge clk);
    StoreReq = 1'b1; Addr = a; StoreData = d; StoreSelector = s; MemReady = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      StoreReq = hold; Addr = 32'h0000_0600; StoreData = 32'h1234_5678; StoreSelector = 2'b10;
      if (cyc == 1) r_busy1 = Busy;
      if (MemRead && MemWrite) r_both = 1'b1;
      if (MemRead) begin
        if (r_rd_cnt == 0) begin r_rd_first = cyc; r_raddr = MemAddr; end
        r_rd_cnt++;
      end
      if (MemWrite) begin
        if (r_wr_cnt == 0) begin r_wr_first = cyc; r_waddr = MemAddr; r_wdata = MemWdata; end
        r_wr_cnt++;
      end
      if (MemRead || MemWrite) begin
        if (!prev) scnt = 0;
        MemReady = (scnt >= rdly);
        scnt++;
        prev = 1'b1;
      end else begin
        MemReady = 1'b0;
        prev = 1'b0;
      end
      if (Done) begin
        r_done = cyc; r_mis = Misaligned; r_tmo = Timeout;
        StoreReq = 1'b0;
        break;
      end
    end
    StoreReq = 1'b0;
    MemReady = 1'b0;
    @(negedge clk);
    check("done_one_cycle", 32'(Done), 32'd0);
    check("idle_after", 32'({Busy, Misaligned, Timeout}), 32'd0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; StoreReq = 1'b0; Addr = '0; StoreData = '0; StoreSelector = '0;
    MemRdata = 32'h1122_3344; MemReady = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_addr", MemAddr, 32'd0);
    check("rst_wdata", MemWdata, 32'd0);
    check("rst_ctrl", 32'({MemRead, MemWrite, Busy, Done, Misaligned, Timeout}), 32'd0);
    rst_n = 1'b1;

    // Word store
    run_store(32'h100, 32'hDEAD_BEEF, 2'b10, 0, 1'b0);
    check("w_busy", 32'(r_busy1), 32'd1);
    check("w_rd_cnt", 32'(r_rd_cnt), 32'd0);
    check("w_wr_first", 32'(r_wr_first), 32'd1);
    check("w_wr_cnt", 32'(r_wr_cnt), 32'd1);
    check("w_waddr", r_waddr, 32'h100);
    check("w_wdata", r_wdata, 32'hDEAD_BEEF);
    check("w_done", 32'(r_done), 32'd2);
    check("w_flags", 32'({r_mis, r_tmo, r_both}), 32'd0);

    // Byte store into lane 3
    run_store(32'h203, 32'h0000_00AB, 2'b00, 0, 1'b0);
    check("b_rd_first", 32'(r_rd_first), 32'd1);
    check("b_raddr", r_raddr, 32'h200);
    check("b_rd_cnt", 32'(r_rd_cnt), 32'd1);
    check("b_wr_first", 32'(r_wr_first), 32'd3);
    check("b_waddr", r_waddr, 32'h200);
    check("b_wdata", r_wdata, 32'hAB22_3344);
    check("b_done", 32'(r_done), 32'd4);
    check("b_flags", 32'({r_mis, r_tmo, r_both}), 32'd0);

    // Byte store into lane 1
    run_store(32'h201, 32'hFFFF_FF55, 2'b00, 0, 1'b0);
    check("b1_wdata", r_wdata, 32'h1122_5544);

    // Halfword stores, upper and lower
    run_store(32'h302, 32'h0000_CAFE, 2'b01, 0, 1'b0);
    check("hu_wdata", r_wdata, 32'hCAFE_3344);
    check("hu_done", 32'(r_done), 32'd4);
    run_store(32'h300, 32'h0000_CAFE, 2'b01, 0, 1'b0);
    check("hl_wdata", r_wdata, 32'h1122_CAFE);
    check("hl_waddr", r_waddr, 32'h300);

    // Misaligned cases: no memory access, Done in cycle 1
    run_store(32'h401, 32'h0000_BEEF, 2'b01, 0, 1'b0);
    check("mh_done", 32'(r_done), 32'd1);
    check("mh_flags", 32'({r_mis, r_tmo}), 32'b10);
    check("mh_access", 32'(r_rd_cnt + r_wr_cnt), 32'd0);
    run_store(32'h402, 32'hDEAD_BEEF, 2'b10, 0, 1'b0);
    check("mw_done", 32'(r_done), 32'd1);
    check("mw_flags", 32'({r_mis, r_tmo}), 32'b10);
    check("mw_access", 32'(r_rd_cnt + r_wr_cnt), 32'd0);
    run_store(32'h500, 32'h0000_0011, 2'b11, 0, 1'b0);
    check("ms_done", 32'(r_done), 32'd1);
    check("ms_flags", 32'({r_mis, r_tmo}), 32'b10);
    check("ms_access", 32'(r_rd_cnt + r_wr_cnt), 32'd0);

    // Memory never answers: read times out after MAX_WAIT cycles
    run_store(32'h203, 32'h0000_00AB, 2'b00, 100, 1'b0);
    check("to_rd_cnt", 32'(r_rd_cnt), 32'd4);
    check("to_wr_cnt", 32'(r_wr_cnt), 32'd0);
    check("to_done", 32'(r_done), 32'd5);
    check("to_flags", 32'({r_mis, r_tmo}), 32'b01);

    // Ready on the last allowed wait cycle of both read and write
    run_store(32'h203, 32'h0000_00AB, 2'b00, 3, 1'b0);
    check("late_rd_cnt", 32'(r_rd_cnt), 32'd4);
    check("late_wr_first", 32'(r_wr_first), 32'd6);
    check("late_wr_cnt", 32'(r_wr_cnt), 32'd4);
    check("late_wdata", r_wdata, 32'hAB22_3344);
    check("late_done", 32'(r_done), 32'd10);
    check("late_flags", 32'({r_mis, r_tmo}), 32'd0);

    // StoreReq held while busy: one store, one Done
    run_store(32'h203, 32'h0000_00AB, 2'b00, 0, 1'b1);
    check("hold_wr_cnt", 32'(r_wr_cnt), 32'd1);
    check("hold_wdata", r_wdata, 32'hAB22_3344);
    check("hold_done", 32'(r_done), 32'd4);
    n = 0;
    repeat (4) begin
      @(negedge clk);
      if (Done || MemWrite || MemRead) n++;
    end
    check("hold_no_extra", 32'(n), 32'd0);

    // Reset while in WRITE
    @(negedge clk);
    StoreReq = 1'b1; Addr = 32'h100; StoreData = 32'hDEAD_BEEF; StoreSelector = 2'b10; MemReady = 1'b0;
    @(negedge clk);
    StoreReq = 1'b0;
    check("rw_in_write", 32'(MemWrite), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rw_addr", MemAddr, 32'd0);
    check("rw_wdata", MemWdata, 32'd0);
    check("rw_ctrl", 32'({MemRead, MemWrite, Busy, Done, Misaligned, Timeout}), 32'd0);
    rst_n = 1'b1;
    n = 0;
    repeat (6) begin
      @(negedge clk);
      if (Done || Busy) n++;
    end
    check("rw_no_done", 32'(n), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
